// File: rtl/multi_echo_timer.sv
// Multi-channel echo pulse-width timer: measures the high time of each echo bit in clk cycles.
// Result is registered one clk after the fall sample; add two clks when ECHO_SYNC_EN is defined.
// Optional macro ECHO_SYNC_EN inserts a 2-flop synchroniser on every echo bit.
module multi_echo_timer #(
  parameter int N_CH    = 4,
  parameter int CNT_W   = 24,
  parameter int MAX_CYC = 600000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_CH-1:0]         echo,
  input  logic [N_CH-1:0]         ack,
  output logic [N_CH*CNT_W-1:0]   duration,
  output logic [N_CH-1:0]         valid,
  output logic [N_CH-1:0]         timeout,
  output logic [N_CH-1:0]         overrun,
  output logic [N_CH-1:0]         busy
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MEASURE  = 2'd1,
    ST_WAIT_LOW = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] MAX_VAL = CNT_W'(MAX_CYC);

  // w_s is the sampled echo; w_smp_ok says w_s reflects real echo rather than reset-cleared flops
  logic [N_CH-1:0] w_s;
  logic            w_smp_ok;

`ifdef ECHO_SYNC_EN
  logic [N_CH-1:0] r_sync1;
  logic [N_CH-1:0] r_sync2;
  logic [1:0]      r_fill;

  // Two-flop synchroniser per bit; r_fill marks when the pipeline holds genuine echo samples
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_fill  <= '0;
    end else begin
      r_sync1 <= echo;
      r_sync2 <= r_sync1;
      r_fill  <= {r_fill[0], 1'b1};
    end
  end

  assign w_s      = r_sync2;
  assign w_smp_ok = r_fill[1];
`else
  assign w_s      = echo;
  assign w_smp_ok = 1'b1;
`endif

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_dur;
    logic             r_prev;
    logic             r_armed;   // echo has been seen low since reset; blocks a bogus rise at release
    logic             r_vld;
    logic             r_to;
    logic             r_ovr;
    logic             r_busy;
    logic             w_rise;
    logic             w_fall;

    assign w_rise = w_s[c] & ~r_prev & r_armed;
    assign w_fall = ~w_s[c] & r_prev;

    // Per-channel measurement FSM with registered result, flags and busy
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_state <= ST_IDLE;
        r_cnt   <= '0;
        r_dur   <= '0;
        r_prev  <= 1'b0;
        r_armed <= 1'b0;
        r_vld   <= 1'b0;
        r_to    <= 1'b0;
        r_ovr   <= 1'b0;
        r_busy  <= 1'b0;
      end else begin
        r_prev <= w_s[c];
        if (w_smp_ok && !w_s[c]) begin
          r_armed <= 1'b1;
        end

        // Consumer ack; a completion in the same clk overrides this below
        if (ack[c] && r_vld) begin
          r_vld <= 1'b0;
          r_ovr <= 1'b0;
        end

        case (r_state)
          ST_IDLE: begin
            if (w_rise) begin
              r_cnt   <= CNT_W'(1);
              r_state <= ST_MEASURE;
              r_busy  <= 1'b1;
            end
          end
          ST_MEASURE: begin
            if (w_fall) begin
              r_dur   <= r_cnt;
              r_vld   <= 1'b1;
              r_to    <= 1'b0;
              r_ovr   <= r_vld & ~ack[c];
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end else if (w_s[c]) begin
              if (r_cnt == MAX_VAL) begin
                // Saturate: report the limit and ignore the rest of this pulse
                r_dur   <= MAX_VAL;
                r_vld   <= 1'b1;
                r_to    <= 1'b1;
                r_ovr   <= r_vld & ~ack[c];
                r_state <= ST_WAIT_LOW;
              end else begin
                r_cnt <= r_cnt + CNT_W'(1);
              end
            end
          end
          ST_WAIT_LOW: begin
            if (!w_s[c]) begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end
          end
          default: begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end

    assign duration[c*CNT_W +: CNT_W] = r_dur;
    assign valid[c]   = r_vld;
    assign timeout[c] = r_to;
    assign overrun[c] = r_ovr;
    assign busy[c]    = r_busy;
  end

endmodule
